// File: rtl/tracklet_mul_pipe_acc.sv
// Pipelined signed multiplier with rounding right shift, saturate/wrap reduction
// and an optional running accumulator in the final stage; valid/ready flow control.
module tracklet_mul_pipe_acc #(
    parameter int unsigned A_WIDTH   = 18,
    parameter int unsigned B_WIDTH   = 17,
    parameter int unsigned P_WIDTH   = 32,
    parameter int unsigned NUM_STAGE = 3,
    parameter int unsigned RSHIFT    = 0,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic signed [A_WIDTH-1:0] din0,
    input  logic signed [B_WIDTH-1:0] din1,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      acc_en,
    input  logic                      acc_clr,
    output logic signed [P_WIDTH-1:0] dout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      ovf
);
    localparam int unsigned PW  = A_WIDTH + B_WIDTH;
    localparam int unsigned XW  = PW + 1;
    localparam int unsigned WW  = ((XW > P_WIDTH) ? XW : P_WIDTH) + 1;
    localparam int unsigned D   = (NUM_STAGE > 1) ? NUM_STAGE - 1 : 1;
    localparam int unsigned RS1 = (RSHIFT > 0) ? RSHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND  = (RSHIFT > 0) ? (XW'(1) << RS1) : '0;
    localparam logic signed [WW-1:0] MAXV = (WW'(1) << (P_WIDTH - 1)) - WW'(1);
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    logic                      advance;
    logic signed [PW-1:0]      prod_in;
    logic signed [PW-1:0]      f_prod;
    logic                      f_vld;
    logic                      f_en;
    logic                      f_clr;
    logic signed [P_WIDTH-1:0] acc;
    logic signed [XW-1:0]      x_full;
    logic [P_WIDTH:0]          x_r;
    logic signed [P_WIDTH-1:0] x_val;
    logic signed [P_WIDTH-1:0] base;
    logic signed [WW-1:0]      sum;
    logic [P_WIDTH:0]          s_r;
    logic signed [P_WIDTH-1:0] acc_nxt;

    // Whole pipeline stalls together whenever the output register is full and blocked.
    assign in_ready = out_ready | ~out_valid;
    assign advance  = in_ready;
    assign prod_in  = PW'(din0) * PW'(din1);

    // Returns {overflow, reduced value}; clamps or wraps according to SATURATE.
    function automatic logic [P_WIDTH:0] reduce(input logic signed [WW-1:0] v);
        logic [P_WIDTH:0] r;
        r = {1'b0, v[P_WIDTH-1:0]};
        if (v > MAXV) begin
            r[P_WIDTH] = 1'b1;
            if (SATURATE != 0) r[P_WIDTH-1:0] = MAXV[P_WIDTH-1:0];
        end else if (v < MINV) begin
            r[P_WIDTH] = 1'b1;
            if (SATURATE != 0) r[P_WIDTH-1:0] = MINV[P_WIDTH-1:0];
        end
        return r;
    endfunction

    if (NUM_STAGE > 1) begin : g_pipe
        logic signed [PW-1:0] prod_q [D];
        logic [D-1:0]         vld_q;
        logic [D-1:0]         en_q;
        logic [D-1:0]         clr_q;

        // Product is registered in the first stage; later stages are pure delay.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                vld_q <= '0;
                en_q  <= '0;
                clr_q <= '0;
                for (int i = 0; i < int'(D); i++) prod_q[i] <= '0;
            end else if (advance) begin
                prod_q[0] <= prod_in;
                vld_q[0]  <= in_valid;
                en_q[0]   <= acc_en;
                clr_q[0]  <= acc_clr;
                for (int i = 1; i < int'(D); i++) begin
                    prod_q[i] <= prod_q[i-1];
                    vld_q[i]  <= vld_q[i-1];
                    en_q[i]   <= en_q[i-1];
                    clr_q[i]  <= clr_q[i-1];
                end
            end
        end

        assign f_prod = prod_q[D-1];
        assign f_vld  = vld_q[D-1];
        assign f_en   = en_q[D-1];
        assign f_clr  = clr_q[D-1];
    end else begin : g_direct
        assign f_prod = prod_in;
        assign f_vld  = in_valid;
        assign f_en   = acc_en;
        assign f_clr  = acc_clr;
    end

    // Final stage: round/shift, reduce, then optional accumulate with the same reduction.
    always_comb begin
        x_full  = (XW'(f_prod) + RND) >>> RSHIFT;
        x_r     = reduce(WW'(x_full));
        x_val   = x_r[P_WIDTH-1:0];
        base    = f_clr ? '0 : acc;
        sum     = WW'(base) + WW'(x_val);
        s_r     = reduce(sum);
        acc_nxt = s_r[P_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout      <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= f_vld;
            if (f_vld) begin
                if (f_en) begin
                    acc  <= acc_nxt;
                    dout <= acc_nxt;
                end else begin
                    dout <= x_val;
                end
                ovf <= ovf | x_r[P_WIDTH] | (f_en & s_r[P_WIDTH]);
            end
        end
    end
endmodule

// File: tb/tb_tracklet_mul_pipe_acc.sv
// Directed bench for tracklet_mul_pipe_acc: default configuration plus small
// 8-bit instances covering saturation, wrap, rounding shift and single-stage latency.
module tb_tracklet_mul_pipe_acc;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;

    logic signed [17:0] din0 = '0;
    logic signed [16:0] din1 = '0;
    logic in_valid = 1'b0, acc_en = 1'b0, acc_clr = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, ovf;
    logic signed [31:0] dout;

    logic signed [7:0] b_a = '0, b_b = '0;
    logic b_valid = 1'b0, b_en = 1'b0, b_clr = 1'b0, b_out_ready = 1'b1;
    logic ready_sat, valid_sat, ovf_sat, ready_wrap, valid_wrap, ovf_wrap;
    logic ready_rs, valid_rs, ovf_rs;
    logic signed [7:0] dout_sat, dout_wrap;
    logic signed [31:0] dout_rs;

    int n_tests = 0;
    int n_fail = 0;

    always #5 ap_clk = ~ap_clk;

    tracklet_mul_pipe_acc dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(din0), .din1(din1),
        .in_valid(in_valid), .in_ready(in_ready), .acc_en(acc_en), .acc_clr(acc_clr),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
    );

    tracklet_mul_pipe_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(8), .NUM_STAGE(2),
                            .RSHIFT(0), .SATURATE(1)) dut_sat (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(b_a), .din1(b_b),
        .in_valid(b_valid), .in_ready(ready_sat), .acc_en(b_en), .acc_clr(b_clr),
        .dout(dout_sat), .out_valid(valid_sat), .out_ready(b_out_ready), .ovf(ovf_sat)
    );

    tracklet_mul_pipe_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(8), .NUM_STAGE(2),
                            .RSHIFT(0), .SATURATE(0)) dut_wrap (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(b_a), .din1(b_b),
        .in_valid(b_valid), .in_ready(ready_wrap), .acc_en(b_en), .acc_clr(b_clr),
        .dout(dout_wrap), .out_valid(valid_wrap), .out_ready(b_out_ready), .ovf(ovf_wrap)
    );

    tracklet_mul_pipe_acc #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(32), .NUM_STAGE(1),
                            .RSHIFT(2), .SATURATE(1)) dut_rs (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(b_a), .din1(b_b),
        .in_valid(b_valid), .in_ready(ready_rs), .acc_en(b_en), .acc_clr(b_clr),
        .dout(dout_rs), .out_valid(valid_rs), .out_ready(b_out_ready), .ovf(ovf_rs)
    );

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (out_valid !== 1'b0 || dout !== 32'sd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b dout=%0d ovf=%0b expected 0 0 0", out_valid, dout, ovf);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
        n_tests++;
        if (ovf_sat !== 1'b0 || ovf_wrap !== 1'b0 || valid_rs !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_small: got ovf_sat=%0b ovf_wrap=%0b valid_rs=%0b expected 0 0 0", ovf_sat, ovf_wrap, valid_rs);
        end
        step();
        step();
        ap_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        din0 = -18'sd3; din1 = 17'sd5; acc_en = 1'b0; acc_clr = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early: got out_valid=%0b expected 0", out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== -32'sd15 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: got valid=%0b dout=%0d ovf=%0b expected 1 -15 0", out_valid, dout, ovf);
        end
    endtask

    task automatic test_back_to_back();
        din0 = 18'sd1000; din1 = 17'sd2; acc_en = 1'b1; acc_clr = 1'b1; in_valid = 1'b1;
        step();
        din0 = -18'sd1; din1 = 17'sd7; acc_en = 1'b1; acc_clr = 1'b0;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd2000) begin
            n_fail++;
            $display("FAIL b2b_first: got valid=%0b dout=%0d expected 1 2000", out_valid, dout);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd1993) begin
            n_fail++;
            $display("FAIL b2b_second: got valid=%0b dout=%0d expected 1 1993", out_valid, dout);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: got out_valid=%0b expected 0", out_valid);
        end
    endtask

    // acc_clr without acc_en must not touch the running sum of 1993.
    task automatic test_acc_en_off();
        din0 = 18'sd10; din1 = 17'sd10; acc_en = 1'b0; acc_clr = 1'b1; in_valid = 1'b1;
        step();
        din0 = 18'sd1; din1 = 17'sd1; acc_en = 1'b1; acc_clr = 1'b0;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd100) begin
            n_fail++;
            $display("FAIL noacc_pass: got valid=%0b dout=%0d expected 1 100", out_valid, dout);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd1994) begin
            n_fail++;
            $display("FAIL noacc_sum: got valid=%0b dout=%0d expected 1 1994", out_valid, dout);
        end
    endtask

    task automatic test_rshift();
        b_a = 8'sd3; b_b = 8'sd1; b_valid = 1'b1;
        step();
        n_tests++;
        if (valid_rs !== 1'b1 || dout_rs !== 32'sd1) begin
            n_fail++;
            $display("FAIL rshift_pos: got valid=%0b dout=%0d expected 1 1", valid_rs, dout_rs);
        end
        b_a = -8'sd3;
        step();
        n_tests++;
        if (dout_rs !== -32'sd1) begin
            n_fail++;
            $display("FAIL rshift_neg: got %0d expected -1", dout_rs);
        end
        b_a = 8'sd6;
        step();
        n_tests++;
        if (dout_rs !== 32'sd2) begin
            n_fail++;
            $display("FAIL rshift_half: got %0d expected 2", dout_rs);
        end
        b_valid = 1'b0;
        step();
    endtask

    task automatic test_sat_wrap();
        b_a = 8'sd5; b_b = -8'sd6; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        step();
        n_tests++;
        if (dout_sat !== -8'sd30 || dout_wrap !== -8'sd30 || ovf_sat !== 1'b0 || ovf_wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL inrange: got sat=%0d wrap=%0d ovf=%0b%0b expected -30 -30 00", dout_sat, dout_wrap, ovf_sat, ovf_wrap);
        end
        b_a = 8'h80; b_b = 8'h80; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        step();
        n_tests++;
        if (valid_sat !== 1'b1 || dout_sat !== 8'sd127 || ovf_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL saturate: got valid=%0b dout=%0d ovf=%0b expected 1 127 1", valid_sat, dout_sat, ovf_sat);
        end
        n_tests++;
        if (valid_wrap !== 1'b1 || dout_wrap !== 8'sd0 || ovf_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: got valid=%0b dout=%0d ovf=%0b expected 1 0 1", valid_wrap, dout_wrap, ovf_wrap);
        end
        step();
        n_tests++;
        if (ovf_sat !== 1'b1 || ovf_wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got %0b%0b expected 11", ovf_sat, ovf_wrap);
        end
    endtask

    task automatic test_stall();
        int sent = 0;
        int got = 0;
        logic stall_ok = 1'b1;
        logic hold_ok = 1'b1;
        logic saw_stall = 1'b0;
        logic prev_stall = 1'b0;
        logic signed [31:0] prev = '0;
        acc_en = 1'b0; acc_clr = 1'b0; din1 = 17'sd1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 2 && cyc < 7);
            in_valid = (sent < 4);
            din0 = 18'(sent + 1);
            #1;
            if (out_valid && !out_ready) begin
                saw_stall = 1'b1;
                if (in_ready !== 1'b0) stall_ok = 1'b0;
            end
            if (prev_stall && dout !== prev) hold_ok = 1'b0;
            if (out_valid && out_ready) begin
                n_tests++;
                if (got >= 4 || dout !== 32'(got + 1)) begin
                    n_fail++;
                    $display("FAIL stall_order: got %0d expected %0d", dout, got + 1);
                end
                got++;
            end
            prev_stall = out_valid && !out_ready;
            prev = dout;
            if (in_valid && in_ready) sent++;
            step();
        end
        out_ready = 1'b1; in_valid = 1'b0;
        n_tests++;
        if (got !== 4 || saw_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results stall_seen=%0b expected 4 1", got, saw_stall);
        end
        n_tests++;
        if (stall_ok !== 1'b1 || hold_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: got in_ready_ok=%0b dout_hold_ok=%0b expected 1 1", stall_ok, hold_ok);
        end
    endtask

    task automatic test_async_reset();
        din0 = 18'sd5; din1 = 17'sd5; acc_en = 1'b1; acc_clr = 1'b1; in_valid = 1'b1;
        step();
        din0 = 18'sd2; din1 = 17'sd2; acc_clr = 1'b0;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd25) begin
            n_fail++;
            $display("FAIL prereset: got valid=%0b dout=%0d expected 1 25", out_valid, dout);
        end
        #2;
        ap_rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || dout !== 32'sd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%0b dout=%0d ovf=%0b expected 0 0 0", out_valid, dout, ovf);
        end
        #1;
        ap_rst_n = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flushed: got out_valid=%0b expected 0", out_valid);
        end
        din0 = 18'sd3; din1 = 17'sd4; acc_en = 1'b1; acc_clr = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; acc_en = 1'b0;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b1 || dout !== 32'sd12) begin
            n_fail++;
            $display("FAIL post_reset_sum: got valid=%0b dout=%0d expected 1 12", out_valid, dout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_acc_en_off();
        test_rshift();
        test_sat_wrap();
        test_stall();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
